// File: rtl/reg_file_arbiter.sv
// Purpose: round-robin arbiter giving the UART controller (M0) and config/debug master (M1) the one regfile port.
// Latency: GNT one cycle after REQ is sampled; write DONE one cycle after GNT; read DONE one cycle after Rd_D_Valid or timeout.
// Backpressure: one transaction in flight; requesters hold REQ and fields until GNT, the loser waits for the next IDLE cycle.
//
// Ports:
//   REF_CLK, SYNC_RST          clock, asynchronous active-low reset
//   Mx_REQ/WR/ADDR/WDATA       requester x transaction request (held until Mx_GNT)
//   Mx_GNT/DONE/RDATA/ERR      requester x grant pulse, completion pulse, read data, timeout flag
//   WrEn/RdEn/Addr/Wr_D        register-file command side
//   Rd_D/Rd_D_Valid            register-file read return
//   BUSY                       a transaction is in flight
module reg_file_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int Reg_Addr  = 4,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 4
) (
  input  logic                 REF_CLK,
  input  logic                 SYNC_RST,

  input  logic                 M0_REQ,
  input  logic                 M0_WR,
  input  logic [Reg_Addr-1:0]  M0_ADDR,
  input  logic [BUS_WIDTH-1:0] M0_WDATA,
  output logic                 M0_GNT,
  output logic                 M0_DONE,
  output logic [BUS_WIDTH-1:0] M0_RDATA,
  output logic                 M0_ERR,

  input  logic                 M1_REQ,
  input  logic                 M1_WR,
  input  logic [Reg_Addr-1:0]  M1_ADDR,
  input  logic [BUS_WIDTH-1:0] M1_WDATA,
  output logic                 M1_GNT,
  output logic                 M1_DONE,
  output logic [BUS_WIDTH-1:0] M1_RDATA,
  output logic                 M1_ERR,

  output logic                 WrEn,
  output logic                 RdEn,
  output logic [Reg_Addr-1:0]  Addr,
  output logic [BUS_WIDTH-1:0] Wr_D,
  input  logic [BUS_WIDTH-1:0] Rd_D,
  input  logic                 Rd_D_Valid,

  output logic                 BUSY
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    READ_WAIT = 2'd3
  } state_t;

  // One request as seen on a requester port and as held for the transaction.
  typedef struct packed {
    logic                 wr;
    logic [Reg_Addr-1:0]  addr;
    logic [BUS_WIDTH-1:0] wdata;
  } req_t;

  // Last READ_WAIT count before giving up; the counter parks here, so it never wraps.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            rr_ptr;
  logic            owner;
  req_t            lat_req;
  req_t            sel_req;
  logic [TO_W-1:0] to_cnt;

  logic grant;
  logic grant_id;
  logic complete;
  logic complete_err;
  logic capture;

  // ------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on a tie rr_ptr decides.
  // ------------------------------------------------------------------
  always_comb begin
    grant_id = rr_ptr;
    if (M0_REQ && !M1_REQ) begin
      grant_id = 1'b0;
    end else if (M1_REQ && !M0_REQ) begin
      grant_id = 1'b1;
    end

    sel_req       = '0;
    sel_req.wr    = grant_id ? M1_WR    : M0_WR;
    sel_req.addr  = grant_id ? M1_ADDR  : M0_ADDR;
    sel_req.wdata = grant_id ? M1_WDATA : M0_WDATA;
  end

  // ------------------------------------------------------------------
  // FSM next state and per-cycle control strobes
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    complete     = 1'b0;
    complete_err = 1'b0;
    capture      = 1'b0;

    case (state)
      IDLE: begin
        if (M0_REQ || M1_REQ) begin
          grant     = 1'b1;
          state_nxt = sel_req.wr ? WRITE : READ;
        end
      end

      WRITE: begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end

      READ: begin
        // A zero-latency regfile may answer in the same cycle as RdEn.
        if (Rd_D_Valid) begin
          complete  = 1'b1;
          capture   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = READ_WAIT;
        end
      end

      READ_WAIT: begin
        // Valid is checked first so data arriving on the last allowed
        // cycle is still returned as a good read.
        if (Rd_D_Valid) begin
          complete  = 1'b1;
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          complete     = 1'b1;
          complete_err = 1'b1;
          state_nxt    = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Register-file command side (combinational from state + held request)
  // ------------------------------------------------------------------
  // The held direction qualifies the strobes so WrEn and RdEn can never
  // be seen together by the register file.
  assign WrEn = (state == WRITE) &&  lat_req.wr;
  assign RdEn = (state == READ)  && !lat_req.wr;
  assign Addr = (state == IDLE)  ? '0 : lat_req.addr;
  assign Wr_D = (state == WRITE) ? lat_req.wdata : '0;
  assign BUSY = (state != IDLE);

  // ------------------------------------------------------------------
  // State, ownership and held request
  // ------------------------------------------------------------------
  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      lat_req <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner   <= grant_id;
        rr_ptr  <= ~grant_id;
        lat_req <= sel_req;
      end
    end
  end

  // READ_WAIT cycle counter: cleared in READ, saturates at TO_LAST.
  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      to_cnt <= '0;
    end else if (state == READ) begin
      to_cnt <= '0;
    end else if ((state == READ_WAIT) && (to_cnt != TO_LAST)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Registered responses, steered to the owning requester only
  // ------------------------------------------------------------------
  always_ff @(posedge REF_CLK or negedge SYNC_RST) begin
    if (!SYNC_RST) begin
      M0_GNT   <= 1'b0;
      M1_GNT   <= 1'b0;
      M0_DONE  <= 1'b0;
      M1_DONE  <= 1'b0;
      M0_ERR   <= 1'b0;
      M1_ERR   <= 1'b0;
      M0_RDATA <= '0;
      M1_RDATA <= '0;
    end else begin
      M0_GNT  <= grant & ~grant_id;
      M1_GNT  <= grant &  grant_id;
      M0_DONE <= complete & ~owner;
      M1_DONE <= complete &  owner;
      M0_ERR  <= complete_err & ~owner;
      M1_ERR  <= complete_err &  owner;

      // RDATA only moves on a read completion; writes leave it alone and a
      // timeout clears it so stale data is never mistaken for a result.
      if (complete && !owner) begin
        if (capture) begin
          M0_RDATA <= Rd_D;
        end else if (complete_err) begin
          M0_RDATA <= '0;
        end
      end
      if (complete && owner) begin
        if (capture) begin
          M1_RDATA <= Rd_D;
        end else if (complete_err) begin
          M1_RDATA <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;

  localparam int BW = 8;
  localparam int AW = 4;
  localparam int TO = 15;
  localparam int TW = 4;

  logic          REF_CLK;
  logic          SYNC_RST;
  logic          M0_REQ, M0_WR, M1_REQ, M1_WR;
  logic [AW-1:0] M0_ADDR, M1_ADDR;
  logic [BW-1:0] M0_WDATA, M1_WDATA;
  logic          M0_GNT, M0_DONE, M0_ERR, M1_GNT, M1_DONE, M1_ERR;
  logic [BW-1:0] M0_RDATA, M1_RDATA;
  logic          WrEn, RdEn, Rd_D_Valid, BUSY;
  logic [AW-1:0] Addr;
  logic [BW-1:0] Wr_D, Rd_D;

  reg_file_arbiter #(.BUS_WIDTH(BW), .Reg_Addr(AW), .TIMEOUT(TO), .TO_W(TW)) dut (
    .REF_CLK(REF_CLK), .SYNC_RST(SYNC_RST),
    .M0_REQ(M0_REQ), .M0_WR(M0_WR), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_GNT(M0_GNT), .M0_DONE(M0_DONE), .M0_RDATA(M0_RDATA), .M0_ERR(M0_ERR),
    .M1_REQ(M1_REQ), .M1_WR(M1_WR), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_GNT(M1_GNT), .M1_DONE(M1_DONE), .M1_RDATA(M1_RDATA), .M1_ERR(M1_ERR),
    .WrEn(WrEn), .RdEn(RdEn), .Addr(Addr), .Wr_D(Wr_D),
    .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid), .BUSY(BUSY)
  );

  initial REF_CLK = 1'b0;
  always #5 REF_CLK = ~REF_CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Register file behaviour driven by the bench
  logic [BW-1:0] rf_mem [16];
  bit rf_busy = 0;
  int rf_cnt  = 0;
  int rf_lat  = 1;
  bit spur_en = 0;
  int lat_opts [8] = '{0, 1, 2, 3, 14, 15, 16, 30};

  // Transaction-level reference model
  logic [BW-1:0] ref_mem [16];
  bit m_free, m_rr, m_wr;
  int m_own, m_t, m_k, m_lat;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wd;
  bit x_gnt [2];
  bit x_done [2];
  bit x_err [2];
  logic [BW-1:0] x_rd [2];

  typedef struct {
    bit r0; bit w0; logic [3:0] a0; logic [7:0] d0;
    bit r1; bit w1; logic [3:0] a1; logic [7:0] d1;
    int lat; int x_own; int x_dly; bit x_err; logic [7:0] x_rd;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_free = 1; m_rr = 0; m_own = 0; m_wr = 0; m_addr = '0; m_wd = '0;
    m_t = 0; m_k = 0; m_lat = 0;
    for (int i = 0; i < 2; i++) begin
      x_gnt[i] = 0; x_done[i] = 0; x_err[i] = 0; x_rd[i] = '0;
    end
  endtask

  // Advance the model by one clock edge given the request inputs seen at it.
  task automatic model_edge(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [3:0] a0, input logic [3:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1);
    for (int i = 0; i < 2; i++) begin
      x_gnt[i] = 0; x_done[i] = 0; x_err[i] = 0;
    end
    if (m_free) begin
      if (r0 || r1) begin
        m_own  = (r0 && r1) ? int'(m_rr) : (r1 ? 1 : 0);
        m_rr   = (m_own == 0);
        m_wr   = m_own ? w1 : w0;
        m_addr = m_own ? a1 : a0;
        m_wd   = m_own ? d1 : d0;
        m_lat  = rf_lat;
        m_k    = 0;
        m_free = 0;
        // cycles from grant to DONE: writes 1, reads min(latency, TIMEOUT)+1
        m_t    = m_wr ? 1 : (((m_lat < TO) ? m_lat : TO) + 1);
        x_gnt[m_own] = 1;
      end
    end else begin
      m_k++;
      m_t--;
      if (m_t == 0) begin
        m_free = 1;
        x_done[m_own] = 1;
        if (m_wr) ref_mem[m_addr] = m_wd;
        else if (m_lat > TO) begin
          x_err[m_own] = 1;
          x_rd[m_own]  = '0;
        end else x_rd[m_own] = ref_mem[m_addr];
      end
    end
  endtask

  task automatic regfile_cycle();
    if (WrEn) rf_mem[Addr] = Wr_D;
    if (RdEn) begin
      rf_busy = 1; rf_cnt = 0;
    end else if (rf_busy) rf_cnt++;
    Rd_D_Valid = 1'b0;
    Rd_D       = 8'($urandom);
    if (rf_busy && rf_cnt == rf_lat) begin
      Rd_D_Valid = 1'b1;
      Rd_D       = rf_mem[Addr];
      rf_busy    = 0;
    end else if (spur_en && !rf_busy && !RdEn && $urandom_range(0, 3) == 0) begin
      Rd_D_Valid = 1'b1;
    end
    if (M0_DONE || M1_DONE) rf_busy = 0;
  endtask

  task automatic check_outputs();
    bit xwe, xre;
    logic [3:0] xa;
    logic [7:0] xwd;
    xwe = !m_free && m_wr && (m_k == 0);
    xre = !m_free && !m_wr && (m_k == 0);
    xa  = m_free ? 4'h0 : m_addr;
    xwd = xwe ? m_wd : 8'h00;
    chk("M0_GNT", M0_GNT, x_gnt[0]);     chk("M1_GNT", M1_GNT, x_gnt[1]);
    chk("M0_DONE", M0_DONE, x_done[0]);  chk("M1_DONE", M1_DONE, x_done[1]);
    chk("M0_ERR", M0_ERR, x_err[0]);     chk("M1_ERR", M1_ERR, x_err[1]);
    chk("M0_RDATA", M0_RDATA, x_rd[0]);  chk("M1_RDATA", M1_RDATA, x_rd[1]);
    chk("WrEn", WrEn, xwe);              chk("RdEn", RdEn, xre);
    chk("Addr", Addr, xa);               chk("Wr_D", Wr_D, xwd);
    chk("BUSY", BUSY, !m_free);
  endtask

  task automatic step();
    bit r0, r1, w0, w1;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    r0 = M0_REQ; r1 = M1_REQ; w0 = M0_WR; w1 = M1_WR;
    a0 = M0_ADDR; a1 = M1_ADDR; d0 = M0_WDATA; d1 = M1_WDATA;
    @(posedge REF_CLK);
    #1;
    cyc++;
    model_edge(r0, r1, w0, w1, a0, a1, d0, d1);
    regfile_cycle();
    check_outputs();
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input logic [3:0] a, input logic [7:0] d);
    if (i == 0) begin
      M0_REQ = r; M0_WR = w; M0_ADDR = a; M0_WDATA = d;
    end else begin
      M1_REQ = r; M1_WR = w; M1_ADDR = a; M1_WDATA = d;
    end
  endtask

  task automatic settle(input string nm);
    int s;
    s = 0;
    while (!m_free && s < 40) begin
      step();
      s++;
    end
    chk(nm, m_free, 1);
  endtask

  initial begin
    int ord [4];
    int gc [4];
    int grants;
    bit pend [2];

    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 8'(i * 17);
      ref_mem[i] = 8'(i * 17);
    end
    tbl[0]  = '{1,1,4'h3,8'h5A, 0,0,4'h0,8'h00,    0, 0, 1, 0, 8'h00};
    tbl[1]  = '{0,0,4'h0,8'h00, 1,0,4'h3,8'h00,    1, 1, 2, 0, 8'h5A};
    tbl[2]  = '{1,1,4'h2,8'h77, 1,1,4'h2,8'h11,    0, 0, 1, 0, 8'h00};
    tbl[3]  = '{1,0,4'h3,8'h00, 1,0,4'h2,8'h00,    0, 1, 1, 0, 8'h77};
    tbl[4]  = '{1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 1000, 0,16, 1, 8'h00};
    tbl[5]  = '{0,0,4'h0,8'h00, 1,1,4'h5,8'h99,    0, 1, 1, 0, 8'h00};
    tbl[6]  = '{1,0,4'h2,8'h00, 0,0,4'h0,8'h00,   15, 0,16, 0, 8'h77};
    tbl[7]  = '{0,0,4'h0,8'h00, 1,0,4'h5,8'h00,    3, 1, 4, 0, 8'h99};
    tbl[8]  = '{1,0,4'hF,8'h00, 0,0,4'h0,8'h00,    2, 0, 3, 0, 8'hFF};
    tbl[9]  = '{1,0,4'h5,8'h00, 1,0,4'h1,8'h00,   14, 1,15, 0, 8'h11};
    tbl[10] = '{0,0,4'h0,8'h00, 1,0,4'h3,8'h00,   16, 1,16, 1, 8'h00};

    SYNC_RST = 1'b0;
    set_req(0, 0, 0, 4'h0, 8'h00);
    set_req(1, 0, 0, 4'h0, 8'h00);
    Rd_D = '0;
    Rd_D_Valid = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge REF_CLK);
    SYNC_RST = 1'b1;

    // ---------------- table-driven transactions ----------------
    for (int v = 0; v < 11; v++) begin
      int g, sg, dly;
      bit got, done;
      rf_lat = tbl[v].lat;
      set_req(0, tbl[v].r0, tbl[v].w0, tbl[v].a0, tbl[v].d0);
      set_req(1, tbl[v].r1, tbl[v].w1, tbl[v].a1, tbl[v].d1);
      got = 0; g = -1; sg = 0;
      for (int s = 0; s < 4 && !got; s++) begin
        step();
        sg++;
        if (M0_GNT || M1_GNT) begin
          got = 1;
          g = M1_GNT ? 1 : 0;
        end
      end
      set_req(0, 0, 0, 4'h0, 8'h00);
      set_req(1, 0, 0, 4'h0, 8'h00);
      chk($sformatf("tbl%0d_owner", v), g, tbl[v].x_own);
      chk($sformatf("tbl%0d_gnt_lat", v), sg, 1);
      if (got) begin
        dly = 0; done = 0;
        for (int s = 0; s < 40 && !done; s++) begin
          step();
          dly++;
          if ((g == 0) ? M0_DONE : M1_DONE) done = 1;
        end
        chk($sformatf("tbl%0d_done_dly", v), done ? dly : -1, tbl[v].x_dly);
        chk($sformatf("tbl%0d_err", v), (g == 0) ? M0_ERR : M1_ERR, tbl[v].x_err);
        if (((g == 0) ? tbl[v].w0 : tbl[v].w1) == 1'b0)
          chk($sformatf("tbl%0d_rdata", v), (g == 0) ? M0_RDATA : M1_RDATA, tbl[v].x_rd);
      end
      settle($sformatf("tbl%0d_idle", v));
    end

    // ---------------- reset in the middle of READ_WAIT ----------------
    rf_lat = 1000;
    set_req(0, 1, 0, 4'h4, 8'h00);
    grants = 0;
    for (int s = 0; s < 4 && grants == 0; s++) begin
      step();
      if (M0_GNT) grants = 1;
    end
    chk("rst_seq_gnt", grants, 1);
    set_req(0, 0, 0, 4'h0, 8'h00);
    repeat (6) step();
    chk("rst_seq_in_wait", BUSY, 1);
    #2;
    SYNC_RST = 1'b0;
    #1;
    model_reset();
    rf_busy = 0;
    check_outputs();
    @(negedge REF_CLK);
    SYNC_RST = 1'b1;
    repeat (3) step();
    set_req(1, 1, 1, 4'h8, 8'h3C);
    step();
    chk("post_rst_m1_gnt", M1_GNT, 1);
    set_req(1, 0, 0, 4'h0, 8'h00);
    settle("post_rst_idle");

    // ---------------- both requesters held: alternation ----------------
    for (int i = 0; i < 4; i++) begin
      ord[i] = -1; gc[i] = 0;
    end
    grants = 0;
    set_req(0, 1, 1, 4'h6, 8'hA0);
    set_req(1, 1, 1, 4'h7, 8'hB1);
    for (int s = 0; s < 24 && grants < 4; s++) begin
      step();
      if (M0_GNT || M1_GNT) begin
        ord[grants] = M1_GNT ? 1 : 0;
        gc[grants]  = cyc;
        grants++;
      end
    end
    set_req(0, 0, 0, 4'h0, 8'h00);
    set_req(1, 0, 0, 4'h0, 8'h00);
    chk("alt_count", grants, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_order%0d", i), ord[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("alt_period%0d", i), gc[i] - gc[i-1], 2);
    settle("alt_idle");

    // ---------------- randomized traffic against the model ----------------
    spur_en = 1;
    pend[0] = 0;
    pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_free) rf_lat = lat_opts[$urandom_range(0, 7)];
      for (int i = 0; i < 2; i++) begin
        bit rq, gn, dn;
        rq = i ? M1_REQ : M0_REQ;
        gn = i ? M1_GNT : M0_GNT;
        dn = i ? M1_DONE : M0_DONE;
        if (dn) pend[i] = 0;
        if (rq && gn) begin
          set_req(i, 0, 0, 4'h0, 8'h00);
          pend[i] = 1;
        end else if (rq && $urandom_range(0, 15) == 0) begin
          set_req(i, 0, 0, 4'h0, 8'h00);
        end else if (!rq && !pend[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1, 1'($urandom), 4'($urandom), 8'($urandom));
        end
      end
      step();
    end
    set_req(0, 0, 0, 4'h0, 8'h00);
    set_req(1, 0, 0, 4'h0, 8'h00);
    settle("rand_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
